// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store port between a core (master) and the data memory responder
// (slave). Two independent valid/ready handshakes: request and response.
//
// Signals:
//   req_valid  master->slave  request present
//   req_ready  slave->master  responder can accept a request
//   req_write  master->slave  1 = store, 0 = load
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data (low bits for byte/half stores)
//   req_func3  master->slave  funct3 of the load/store instruction
//   rsp_valid  slave->master  response present
//   rsp_ready  master->slave  initiator accepts the response
//   rsp_rdata  slave->master  extended load data, 0 for stores and errors
//   rsp_err    slave->master  access error
// -----------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_func3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_func3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for a core load/store port. Accepts one request at a
// time, waits LATENCY cycles, performs a byte/half/word access on a word-wide
// little-endian array, and holds the response until the initiator takes it.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (array contents are not reset)
//   bus  dmem_responder_if.slave request/response handshakes
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of 2)
//   LATENCY      wait-state cycles, 0..15
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses report
//                          rsp_err; otherwise they are force-aligned.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_count;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_func3;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_doAccess;
  logic          w_write;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_func3;
  logic          w_inRange;
  logic          w_legal;
  logic          w_misaligned;
  logic          w_err;
  logic [1:0]    w_lane;
  logic [AW-1:0] w_index;
  logic [31:0]   w_word;
  logic [31:0]   w_shifted;
  logic [31:0]   w_loadData;
  logic [31:0]   w_rdata;
  logic [3:0]    w_be;
  logic [31:0]   w_wmerge;
  logic          w_memWrite;

  assign w_accept = (r_state == IDLE) && bus.req_valid;

  // With zero wait states the access happens on the accepting edge, before the
  // latches hold anything, so the access operands come straight from the bus.
  assign w_write = (r_state == IDLE) ? bus.req_write : r_write;
  assign w_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;
  assign w_func3 = (r_state == IDLE) ? bus.req_func3 : r_func3;

  assign w_doAccess = (w_accept && (LAT == 4'd0)) ||
                      ((r_state == WAIT) && (r_count == 4'd1));

  // Access decode: range, legality, alignment, lane selection and data shaping.
  always_comb begin
    w_inRange    = (w_addr >> (AW + 2)) == 32'd0;
    w_legal      = w_write ? (w_func3 inside {3'b000, 3'b001, 3'b010})
                           : (w_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    w_misaligned = ((w_func3[1:0] == 2'b01) && w_addr[0]) ||
                   ((w_func3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    w_err = !w_inRange || !w_legal || w_misaligned;
`else
    w_err = !w_inRange || !w_legal;
`endif

    // Force-aligned lane: low address bits below the access size are dropped.
    case (w_func3[1:0])
      2'b00:   w_lane = w_addr[1:0];
      2'b01:   w_lane = {w_addr[1], 1'b0};
      default: w_lane = 2'b00;
    endcase

    w_index   = w_addr[AW+1:2];
    w_word    = r_mem[w_index];
    w_shifted = w_word >> {w_lane, 3'b000};

    case (w_func3)
      3'b000:  w_loadData = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_loadData = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_loadData = w_shifted;
      3'b100:  w_loadData = {24'd0, w_shifted[7:0]};
      3'b101:  w_loadData = {16'd0, w_shifted[15:0]};
      default: w_loadData = 32'd0;
    endcase
    w_rdata = (w_err || w_write) ? 32'd0 : w_loadData;

    // Store data is replicated across lanes; the byte enables pick the lanes.
    case (w_func3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wmerge = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be     = 4'b0011 << w_lane;
        w_wmerge = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be     = 4'b1111;
        w_wmerge = w_wdata;
      end
    endcase

    w_memWrite = w_doAccess && w_write && !w_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_nextState = (LAT == 4'd0) ? RESP : WAIT;
      end
      WAIT: begin
        if (r_count == 4'd1) w_nextState = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_func3 <= 3'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_func3 <= bus.req_func3;
        r_count <= LAT;
      end else if (r_state == WAIT) begin
        r_count <= r_count - 4'd1;
      end
      if (w_doAccess) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end
    end
  end

  // The array has no reset; gating on rst keeps a store from landing on an
  // edge where reset is already asserted.
  always_ff @(posedge clk) begin
    if (!rst && w_memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_index][8*b +: 8] <= w_wmerge[8*b +: 8];
      end
    end
  end

  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Scoreboard bench for dmem_responder. Requests are issued by a driver that
// pushes the reference-model result into a queue; an independent monitor pops
// and compares whenever a response appears, and randomises rsp_ready.
// A second instance with LATENCY=0 and a 16-word array covers the
// zero-wait-state path and a small-array range boundary.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int LAT    = 2;
  localparam int DEPTH0 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder_if bus0();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH0), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        hold;
    logic [31:0] acc;
  } exp_t;

  exp_t        expQ[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cycle  = 0;
  logic [7:0]  refMem [0:4*DEPTH-1];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Reference model: byte-addressed memory, access rules applied arithmetically.
  function automatic void modelAccess(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [2:0] f3, output logic [31:0] rdata, output logic err);
    int          nbytes;
    longint      val;
    logic [31:0] base;
    bit          legal;
    bit          misal;
    nbytes = 1 << f3[1:0];
    legal  = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misal  = (addr % nbytes) != 0;
    err    = !legal || (addr >= 4 * DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (misal) err = 1'b1;
`endif
    rdata = 32'd0;
    if (err) return;
    base = addr - (addr % nbytes);
    if (wr) begin
      for (int i = 0; i < nbytes; i++) refMem[base + i] = 8'(wdata >> (8 * i));
    end else begin
      val = 0;
      for (int i = 0; i < nbytes; i++) val += longint'(refMem[base + i]) << (8 * i);
      if (!f3[2] && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
        val -= longint'(1) << (8 * nbytes);
      rdata = val[31:0];
    end
  endfunction

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] f3, input logic hold);
    int          waitCnt;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    waitCnt = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 100) begin
      checkOutput("reqReadyTimeout", 32'(bus.req_ready), 32'd1);
      return;
    end
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_func3 = f3;
    bus.req_valid = 1'b1;
    modelAccess(wr, addr, wdata, f3, rd, er);
    e.rdata = rd;
    e.err   = er;
    e.hold  = hold;
    e.acc   = cycle + 1;
    expQ.push_back(e);
    @(negedge clk);
    // Scramble the request fields so only the latched copy can be used.
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_func3 = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.rsp_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
  endtask

  task automatic lat0Access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                            input logic [31:0] expRdata, input logic expErr, input string name);
    int n;
    @(negedge clk);
    checkOutput({name, "_reqReady"}, 32'(bus0.req_ready), 32'd1);
    bus0.req_write = wr;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    bus0.req_func3 = f3;
    bus0.req_valid = 1'b1;
    @(negedge clk);
    bus0.req_valid = 1'b0;
    n = 1;
    while (bus0.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'd1);
    checkOutput({name, "_rdata"}, bus0.rsp_rdata, expRdata);
    checkOutput({name, "_err"}, 32'(bus0.rsp_err), 32'(expErr));
  endtask

  // Monitor: pops the scoreboard on each new response, checks hold stability,
  // and drives rsp_ready (forced low for 5 cycles on responses marked hold).
  initial begin : monitor
    bit          inResp;
    bit          justDone;
    int          holdLeft;
    logic [31:0] heldRdata;
    logic        heldErr;
    exp_t        e;
    inResp        = 0;
    justDone      = 0;
    holdLeft      = 0;
    heldRdata     = '0;
    heldErr       = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inResp        = 0;
        justDone      = 0;
        bus.rsp_ready = 1'b0;
      end else begin
        if (justDone) begin
          checkOutput("idleAfterRsp", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
          justDone = 0;
        end
        if (bus.rsp_valid) begin
          if (!inResp) begin
            inResp = 1;
            if (expQ.size() == 0) begin
              checkOutput("unexpectedRsp", 32'(expQ.size()), 32'd1);
            end else begin
              e = expQ.pop_front();
              checkOutput("rdata", bus.rsp_rdata, e.rdata);
              checkOutput("err", 32'(bus.rsp_err), 32'(e.err));
              checkOutput("latency", cycle + 1 - e.acc, 32'(LAT + 1));
              if (e.hold) holdLeft = 5;
            end
            heldRdata = bus.rsp_rdata;
            heldErr   = bus.rsp_err;
          end else begin
            checkOutput("holdRdata", bus.rsp_rdata, heldRdata);
            checkOutput("holdErr", 32'(bus.rsp_err), 32'(heldErr));
          end
          checkOutput("reqReadyInRsp", 32'(bus.req_ready), 32'd0);
          if (holdLeft > 0) begin
            bus.rsp_ready = 1'b0;
            holdLeft--;
          end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
          end
          if (bus.rsp_ready) begin
            inResp   = 0;
            justDone = 1;
          end
        end else begin
          bus.rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : stimulus
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  f3;
    int          r;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_func3  = '0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.req_func3 = '0;
    bus0.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstReqReady", 32'(bus.req_ready), 32'd1);
    checkOutput("rstRspValid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rstRdata", bus.rsp_rdata, 32'd0);
    checkOutput("rstErr", 32'(bus.rsp_err), 32'd0);
    checkOutput("rstReqReady0", 32'(bus0.req_ready), 32'd1);
    rst = 1'b0;

    // Give every word in the random window, plus the top word, a known value.
    for (int w = 0; w < 16; w++) applyStimulus(1'b1, 32'(w * 4), $urandom, 3'b010, 1'b0);
    applyStimulus(1'b1, 32'hFFC, 32'hCAFE_F00D, 3'b010, 1'b0);

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b1, 32'h11, 32'h0000_00A5, 3'b000, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'h11, 32'h0, 3'b000, 1'b0);
    applyStimulus(1'b0, 32'h11, 32'h0, 3'b100, 1'b0);
    applyStimulus(1'b0, 32'h12, 32'h0, 3'b001, 1'b0);
    applyStimulus(1'b0, 32'h12, 32'h0, 3'b101, 1'b0);
    applyStimulus(1'b1, 32'h10, 32'h0000_1234, 3'b001, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'h11, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b1, 32'h13, 32'h5555_AAAA, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
    applyStimulus(1'b0, 32'h1000, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'hFFC, 32'h0, 3'b010, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 3'b011, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h1111_2222, 3'b011, 1'b0);
    applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
    drain();

    // Abort a store while it is still waiting; its write must never land.
    @(negedge clk);
    checkOutput("abortStartReady", 32'(bus.req_ready), 32'd1);
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h7777_7777;
    bus.req_func3 = 3'b010;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("abortReqReady", 32'(bus.req_ready), 32'd1);
    checkOutput("abortRspValid", 32'(bus.rsp_valid), 32'd0);
    applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
    drain();

    for (int i = 0; i < 250; i++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
      else if (r == 1) addr = $urandom | 32'h8000_0000;
      else             addr = 32'($urandom_range(0, 63));
      applyStimulus(wr, addr, $urandom, f3, 1'($urandom_range(0, 15) == 0));
    end
    drain();

    lat0Access(1'b1, 32'h4, 32'h1234_5678, 3'b010, 32'h0, 1'b0, "l0Sw");
    lat0Access(1'b0, 32'h4, 32'h0, 3'b010, 32'h1234_5678, 1'b0, "l0Lw");
    lat0Access(1'b0, 32'h6, 32'h0, 3'b001, 32'h0000_1234, 1'b0, "l0Lh");
    lat0Access(1'b0, 32'h4, 32'h0, 3'b100, 32'h0000_0078, 1'b0, "l0Lbu");
    lat0Access(1'b0, 32'h40, 32'h0, 3'b010, 32'h0, 1'b1, "l0Range");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake, performs the access, and returns the result over a second valid/ready handshake.
- Performs the byte, half and word access, sign or zero extension, and alignment checking selected by funct3.
- Inserts a parameterisable number of wait states, so multi-cycle pipelined cores can be exercised against realistic memory latency.
- Sits between the core datapath (ALU address, rs2 store data, funct3) and a word-organised, little-endian storage array.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of 2.
- LATENCY, 2: wait-state cycles between request acceptance and response; range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low bits are used for byte and half stores.
- req_func3  input  3  funct3 of the load/store instruction.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  access error (misaligned, out of range, or illegal funct3).

Behaviour:
- States: IDLE, WAIT, RESP.
  - Reset enters IDLE.
  - Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - The storage array is not reset.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch write, addr, wdata and func3; load the counter with LATENCY.
  - Go to WAIT if LATENCY>0, otherwise perform the access and go to RESP.
- WAIT:
  - req_ready=0; the counter decrements each cycle.
  - When the counter reaches 1, perform the access on that edge and go to RESP.
- Timing: rsp_valid first asserts exactly LATENCY+1 cycles after the accepting edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid&rsp_ready edge, return to IDLE with rsp_valid=0.
  - There is no back-to-back bypass, so the minimum request spacing is LATENCY+2 cycles.
- Request inputs are ignored outside IDLE. Latched values are used throughout the access, so a changing req_* does not affect an access in flight.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; byte lane = addr[1:0].
  - Little-endian: lane 0 is bits 7:0.
- Out of range: addr >= 4*DEPTH_WORDS gives rsp_err=1, no write, rdata=0.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected half.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected half.
  - Other funct3 values: err=1.
- Stores:
  - 000 SB: write only the selected byte lane.
  - 001 SH: write only the selected half.
  - 010 SW: write the full word.
  - Other funct3 values: err=1, no write.
  - Untouched lanes keep their value.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Reset mid-operation: an asynchronous rst in WAIT or RESP aborts and returns to IDLE. A store whose write edge has not yet occurred is not performed. A store already written stays written.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned halfword or word accesses give rsp_err=1, rdata=0, and no array write.
- Undefined: misaligned accesses are force-aligned. The low address bits are ignored (addr[0] for half, addr[1:0] for word), the access completes normally, and rsp_err=0 for the alignment case.
- Out-of-range and illegal-funct3 errors are reported in both builds.

Test Plan:
1. Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 (LATENCY=2) -> each rsp_valid rises 3 cycles after acceptance; LW returns rdata=0xDEADBEEF, err=0.
2. After test 1: SB addr=0x11 wdata=0x000000A5, then LW 0x10 -> 0xDEADA5EF. LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5.
3. LH 0x12 on word 0xDEADA5EF -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD. SH 0x10 wdata=0x1234, then LW 0x10 -> 0xDEAD1234.
4. With DMEM_MISALIGN_TRAP_EN: LW 0x11 -> err=1, rdata=0; SW 0x13 leaves the word unchanged. Without the macro: LW 0x11 -> the word at 0x10, err=0.
5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err stay constant, and req_ready=0 throughout. Raise rsp_ready -> back to IDLE the next cycle with req_ready=1.
6. Boundary and abort cases (DEPTH_WORDS=1024):
   - LW 0x1000 -> err=1.
   - funct3=011 -> err=1.
   - LATENCY=0 build -> rsp_valid 1 cycle after acceptance.
   - rst pulse during WAIT of SW 0x20 -> state IDLE, and a later LW 0x20 shows the old value.
